garage_gate_sensor: RTL and testbench
=====================================

# garage_gate_sensor

Event source for the car-park occupancy counter. It watches two beam sensors across the gate lane: outer `s_out` on the street side and inner `s_in` on the garage side. It decodes the order in which the beams are blocked and cleared, and emits exactly one entry or exit event per complete car passage. It also reports the full condition from the current occupancy count, drives the entry-gate enable, and flags aborted, ambiguous and stalled passages.

## Interface
- `CAPACITY`, 50: occupancy at which the garage is full.
- `TIMEOUT`, 1000: maximum cycles a passage may stay in progress.
- `DEBOUNCE_CYCLES`, 8: stable cycles required per sensor; used only with `GATE_DEBOUNCE_EN`.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `s_out`  in  1  raw outer beam, 1 = blocked, asynchronous to `clk`.
- `s_in`  in  1  raw inner beam, 1 = blocked, asynchronous to `clk`.
- `count`  in  6  current occupancy, 0..63.
- `ev_valid`  out  1  one-cycle event strobe.
- `ev_dir`  out  1  event direction: 1 = entry, 0 = exit; meaningful only while `ev_valid` is high.
- `full`  out  1  registered `count >= CAPACITY`.
- `gate_en`  out  1  entry gate may open.
- `fault`  out  1  one-cycle pulse on a timeout, an ambiguous start, or an entry completed while full.

## Operation
- Both raw sensors pass through a 2-FF synchronizer, then through the optional debounce stage. The result is the cleaned pair A (outer) and B (inner).
- FSM states and transitions, written as (A,B):
  - IDLE:
    - (1,0) → EN1.
    - (0,1) → EX1.
    - (1,1) → AMBIG, with a `fault` pulse.
  - Entry path:
    - EN1: (1,1) → EN2; (0,0) → IDLE with no event (abort); (0,1) → AMBIG.
    - EN2: (0,1) → EN3; (1,0) → EN1 (car backing out); (0,0) → AMBIG.
    - EN3: (0,0) → IDLE with `ev_valid=1`, `ev_dir=1`; (1,1) → EN2; (1,0) → AMBIG.
  - Exit path mirrors the entry path with A and B swapped: EX1 → EX2 → EX3. EX3 on (0,0) → IDLE with `ev_valid=1`, `ev_dir=0`.
  - AMBIG: stays until (0,0), then → IDLE. No event is emitted.
  - Any state other than IDLE or AMBIG for `TIMEOUT` consecutive cycles → AMBIG, with a `fault` pulse.
- The timeout counter clears on every state change and saturates once it reaches `TIMEOUT`.
- An entry event completed while `full=1` is still emitted, and `fault` pulses in the same cycle.
- `gate_en` = IDLE or EN1, and `full=0`. It is registered.
- `full` is recomputed every cycle from `count`. A `count` value above `CAPACITY` still reads as full.
- At most one event per passage. `ev_valid` is never high on two consecutive cycles.

## Timing
- Reset values: state IDLE, synchronizer and debounce regs 0, `ev_valid=0`, `ev_dir=0`, `full=0`, `gate_en=0`, `fault=0`, timeout counter 0.
- Latency from a raw sensor edge to the FSM:
  - 3 clk without debounce (2 sync + 1 state).
  - 3 + `DEBOUNCE_CYCLES` clk with debounce.
- `ev_valid`, `ev_dir` and `fault` are registered. They are high in the cycle the state register enters IDLE or AMBIG.
- `full` follows `count` with 1 clk latency. `gate_en` follows `full` and the state with 1 clk latency.
- Reset asserted mid-passage: all regs return to reset values immediately. No event is emitted, and the partial passage is lost.
- The first cycle after reset release evaluates from IDLE. If sensors are already blocked at that point, the IDLE rules above apply.

## Configuration
- `GATE_DEBOUNCE_EN` defined:
  - Each synchronized sensor feeds a counter.
  - The cleaned value changes only after `DEBOUNCE_CYCLES` consecutive cycles of the new level.
  - A glitch shorter than that is ignored.
- `GATE_DEBOUNCE_EN` undefined: the cleaned value equals the synchronizer output. No debounce logic exists and `DEBOUNCE_CYCLES` is unused.

## Structure
- Package `garage_pkg`:
  - state enum: IDLE, EN1, EN2, EN3, EX1, EX2, EX3, AMBIG.
  - `CAP_DEFAULT` = 50.
  - `DIR_ENTRY` = 1, `DIR_EXIT` = 0.
- Sub-module `beam_debounce`: one instance per sensor, containing the synchronizer plus the optional debounce counter.

## Test plan
- Entry sequence (1,0)→(1,1)→(0,1)→(0,0), each held 5 cycles, `count=10` → exactly one `ev_valid` with `ev_dir=1`, `fault=0`.
- Exit sequence (0,1)→(1,1)→(1,0)→(0,0) → one `ev_valid` with `ev_dir=0`.
- Backout (1,0)→(1,1)→(1,0)→(0,0) → no event, no fault, FSM back in IDLE.
- Both beams blocked from IDLE → `fault` pulse, no event. Then (0,0) → IDLE.
- `count=50`: `full=1` and `gate_en=0`. A full entry sequence then gives `ev_valid`, `ev_dir=1`, and `fault` in the same cycle.
- Hold (1,0) for `TIMEOUT`+5 cycles → `fault` pulse at `TIMEOUT`. Assert reset mid-passage → all outputs 0 and no event. With `GATE_DEBOUNCE_EN`, a 3-cycle glitch on `s_out` → no state change.

Source files
------------

// File: rtl/garage_pkg.sv
// Shared types and constants for the garage gate sensor.
package garage_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      EN1   = 3'd1,
      EN2   = 3'd2,
      EN3   = 3'd3,
      EX1   = 3'd4,
      EX2   = 3'd5,
      EX3   = 3'd6,
      AMBIG = 3'd7
   } gate_state_e;

   localparam int unsigned CAP_DEFAULT = 50;

   localparam logic DIR_ENTRY = 1'b1;
   localparam logic DIR_EXIT  = 1'b0;

endpackage

// File: rtl/garage_gate_sensor_beam_debounce.sv
// Per-beam cleaner: 2-FF synchronizer plus optional debounce counter.
// Debounce is built only when GATE_DEBOUNCE_EN is defined.
module beam_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level
);

   // A zero-cycle debounce window has no meaning; reject it at elaboration.
   if (DEBOUNCE_CYCLES == 0) begin : g_bad_cfg
      $error("beam_debounce: DEBOUNCE_CYCLES must be at least 1");
   end

   logic sync1_q, sync2_q;

   // Two-stage synchronizer for the asynchronous beam input.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

`ifdef GATE_DEBOUNCE_EN
   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic             clean_q, clean_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Count consecutive cycles at a new level; adopt it once the window is met.
   always_comb begin
      clean_d = clean_q;
      cnt_d   = '0;
      if (sync2_q != clean_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            clean_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Debounce state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clean_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         clean_q <= clean_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = clean_q;
`else
   assign level = sync2_q;
`endif

endmodule

// File: rtl/garage_gate_sensor.sv
// Gate-lane passage decoder: turns the outer/inner beam sequence into one
// entry/exit event per car, reports full, drives the entry-gate enable and
// flags ambiguous, stalled and over-capacity passages.
// Optional debounce stage: define GATE_DEBOUNCE_EN.
module garage_gate_sensor
   import garage_pkg::*;
#(
   parameter int unsigned CAPACITY        = CAP_DEFAULT,
   parameter int unsigned TIMEOUT         = 1000,
   parameter int unsigned DEBOUNCE_CYCLES = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       s_out,
   input  logic       s_in,
   input  logic [5:0] count,
   output logic       ev_valid,
   output logic       ev_dir,
   output logic       full,
   output logic       gate_en,
   output logic       fault
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

   logic             a, b;
   gate_state_e      state_q, state_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             ev_valid_q, ev_valid_d;
   logic             ev_dir_q, ev_dir_d;
   logic             fault_q, fault_d;
   logic             full_q, full_d;
   logic             gate_en_q, gate_en_d;

   beam_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_beam_out (
      .clk   (clk),
      .reset (reset),
      .raw   (s_out),
      .level (a)
   );

   beam_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_beam_in (
      .clk   (clk),
      .reset (reset),
      .raw   (s_in),
      .level (b)
   );

   // Passage decode, stall timeout, event/fault strobes, full and gate enable.
   always_comb begin
      state_d    = state_q;
      ev_valid_d = 1'b0;
      ev_dir_d   = 1'b0;
      fault_d    = 1'b0;

      case (state_q)
         IDLE: begin
            case ({a, b})
               2'b10:   state_d = EN1;
               2'b01:   state_d = EX1;
               2'b11: begin
                  state_d = AMBIG;
                  fault_d = 1'b1;
               end
               default: state_d = IDLE;
            endcase
         end
         EN1: begin
            case ({a, b})
               2'b11:   state_d = EN2;
               2'b00:   state_d = IDLE;
               2'b01:   state_d = AMBIG;
               default: state_d = EN1;
            endcase
         end
         EN2: begin
            case ({a, b})
               2'b01:   state_d = EN3;
               2'b10:   state_d = EN1;
               2'b00:   state_d = AMBIG;
               default: state_d = EN2;
            endcase
         end
         EN3: begin
            case ({a, b})
               2'b00: begin
                  state_d    = IDLE;
                  ev_valid_d = 1'b1;
                  ev_dir_d   = DIR_ENTRY;
                  fault_d    = full_q;
               end
               2'b11:   state_d = EN2;
               2'b10:   state_d = AMBIG;
               default: state_d = EN3;
            endcase
         end
         EX1: begin
            case ({a, b})
               2'b11:   state_d = EX2;
               2'b00:   state_d = IDLE;
               2'b10:   state_d = AMBIG;
               default: state_d = EX1;
            endcase
         end
         EX2: begin
            case ({a, b})
               2'b10:   state_d = EX3;
               2'b01:   state_d = EX1;
               2'b00:   state_d = AMBIG;
               default: state_d = EX2;
            endcase
         end
         EX3: begin
            case ({a, b})
               2'b00: begin
                  state_d    = IDLE;
                  ev_valid_d = 1'b1;
                  ev_dir_d   = DIR_EXIT;
               end
               2'b11:   state_d = EX2;
               2'b01:   state_d = AMBIG;
               default: state_d = EX3;
            endcase
         end
         AMBIG: begin
            if ({a, b} == 2'b00) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A passage sitting in one state for TIMEOUT cycles is abandoned.
      if ((state_d == state_q) && (state_q != IDLE) && (state_q != AMBIG) &&
          (tmo_q == TMO_W'(TIMEOUT - 1))) begin
         state_d = AMBIG;
         fault_d = 1'b1;
      end

      if (state_d != state_q) begin
         tmo_d = '0;
      end else if (tmo_q == TMO_W'(TIMEOUT)) begin
         tmo_d = tmo_q;
      end else begin
         tmo_d = tmo_q + TMO_W'(1);
      end

      full_d    = (32'(count) >= CAPACITY);
      gate_en_d = ((state_q == IDLE) || (state_q == EN1)) && !full_q;
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         tmo_q      <= '0;
         ev_valid_q <= 1'b0;
         ev_dir_q   <= 1'b0;
         fault_q    <= 1'b0;
         full_q     <= 1'b0;
         gate_en_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmo_q      <= tmo_d;
         ev_valid_q <= ev_valid_d;
         ev_dir_q   <= ev_dir_d;
         fault_q    <= fault_d;
         full_q     <= full_d;
         gate_en_q  <= gate_en_d;
      end
   end

   assign ev_valid = ev_valid_q;
   assign ev_dir   = ev_dir_q;
   assign fault    = fault_q;
   assign full     = full_q;
   assign gate_en  = gate_en_q;

endmodule

// File: tb/tb_garage_gate_sensor.sv
// Self-checking bench for garage_gate_sensor: a scoreboard of expected
// event/fault strobes checked by a monitor, plus per-scenario checks.
module tb_garage_gate_sensor;

   localparam int unsigned CAPACITY = 50;
   localparam int unsigned TIMEOUT  = 1000;
   localparam int unsigned DEB      = 8;
`ifdef GATE_DEBOUNCE_EN
   localparam int HOLD = 12;
   localparam int LAT  = 3 + DEB;
`else
   localparam int HOLD = 5;
   localparam int LAT  = 3;
`endif

   typedef struct packed {
      logic v;
      logic d;
      logic f;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       s_out, s_in;
   logic [5:0] count;
   logic       ev_valid, ev_dir, full, gate_en, fault;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   logic prev_valid = 1'b0;

   garage_gate_sensor #(
      .CAPACITY        (CAPACITY),
      .TIMEOUT         (TIMEOUT),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .s_out    (s_out),
      .s_in     (s_in),
      .count    (count),
      .ev_valid (ev_valid),
      .ev_dir   (ev_dir),
      .full     (full),
      .gate_en  (gate_en),
      .fault    (fault)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: every strobe must match the next expected record.
   always @(negedge clk) begin
      if (ev_valid || fault) begin
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_strobe: ev_valid=%b ev_dir=%b fault=%b, required none",
                     ev_valid, ev_dir, fault);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (ev_valid !== e.v || fault !== e.f || (e.v && ev_dir !== e.d)) begin
               n_fail++;
               $display("FAIL strobe: got v=%b d=%b f=%b, required v=%b d=%b f=%b",
                        ev_valid, ev_dir, fault, e.v, e.d, e.f);
            end
         end
      end
      if (ev_valid && prev_valid) begin
         n_tests++;
         n_fail++;
         $display("FAIL back_to_back_valid: ev_valid high two cycles, required single pulse");
      end
      prev_valid = ev_valid;
   end

   task automatic hold(input logic a, input logic b, input int n);
      s_out = a;
      s_in  = b;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_drained(input string name);
      hold(1'b0, 1'b0, 10);
      n_tests++;
      if (sb.size() !== 0) begin
         n_fail++;
         $display("FAIL %s_drained: %0d strobes pending, required 0", name, sb.size());
      end
      sb.delete();
   endtask

   task automatic test_reset;
      reset = 1'b1; s_out = 1'b0; s_in = 1'b0; count = 6'd10;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({ev_valid, ev_dir, full, gate_en, fault} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b, required 00000",
                  {ev_valid, ev_dir, full, gate_en, fault});
      end
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(posedge clk); #1;
      n_tests++;
      if (gate_en !== 1'b1 || full !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset: gate_en=%b full=%b, required 1 0", gate_en, full);
      end
   endtask

   task automatic test_entry;
      count = 6'd10;
      sb.push_back('{v: 1'b1, d: 1'b1, f: 1'b0});
      hold(1, 0, HOLD); hold(1, 1, HOLD); hold(0, 1, HOLD); hold(0, 0, HOLD);
      check_drained("entry");
   endtask

   task automatic test_exit;
      sb.push_back('{v: 1'b1, d: 1'b0, f: 1'b0});
      hold(0, 1, HOLD); hold(1, 1, HOLD); hold(1, 0, HOLD); hold(0, 0, HOLD);
      check_drained("exit");
   endtask

   task automatic test_backout;
      hold(1, 0, HOLD); hold(1, 1, HOLD); hold(1, 0, HOLD); hold(0, 0, HOLD);
      check_drained("backout");
      // Still in IDLE: a following entry decodes normally.
      sb.push_back('{v: 1'b1, d: 1'b1, f: 1'b0});
      hold(1, 0, HOLD); hold(1, 1, HOLD); hold(0, 1, HOLD); hold(0, 0, HOLD);
      check_drained("after_backout");
   endtask

   task automatic test_ambig;
      sb.push_back('{v: 1'b0, d: 1'b0, f: 1'b1});
      hold(1, 1, HOLD); hold(1, 0, HOLD); hold(0, 0, HOLD);
      check_drained("ambig");
      sb.push_back('{v: 1'b1, d: 1'b0, f: 1'b0});
      hold(0, 1, HOLD); hold(1, 1, HOLD); hold(1, 0, HOLD); hold(0, 0, HOLD);
      check_drained("after_ambig");
   endtask

   task automatic test_full;
      logic [5:0] cvals [4] = '{6'd49, 6'd50, 6'd63, 6'd10};
      logic       fexp  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         count = cvals[i];
         hold(0, 0, 3);
         n_tests++;
         if (full !== fexp[i] || gate_en !== !fexp[i]) begin
            n_fail++;
            $display("FAIL full_count%0d: full=%b gate_en=%b, required %b %b",
                     cvals[i], full, gate_en, fexp[i], !fexp[i]);
         end
      end
      count = 6'd50;
      hold(0, 0, 3);
      sb.push_back('{v: 1'b1, d: 1'b1, f: 1'b1});
      hold(1, 0, HOLD);
      n_tests++;
      if (gate_en !== 1'b0) begin
         n_fail++;
         $display("FAIL full_gate_en_en1: got %b, required 0", gate_en);
      end
      hold(1, 1, HOLD); hold(0, 1, HOLD); hold(0, 0, HOLD);
      check_drained("full_entry");
      count = 6'd10;
      hold(0, 0, 3);
   endtask

   task automatic test_timeout;
      int   edges = 0;
      logic found = 1'b0;
      sb.push_back('{v: 1'b0, d: 1'b0, f: 1'b1});
      s_out = 1'b1; s_in = 1'b0;
      for (int i = 0; i < int'(TIMEOUT) + LAT + 20 && !found; i++) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (fault) found = 1'b1;
      end
      n_tests++;
      if (!found || edges != int'(TIMEOUT) + LAT) begin
         n_fail++;
         $display("FAIL timeout_latency: found=%b after %0d cycles, required %0d",
                  found, edges, int'(TIMEOUT) + LAT);
      end
      @(posedge clk); #1;
      hold(1, 0, 5);
      check_drained("timeout");
   endtask

   task automatic test_reset_mid;
      hold(1, 0, HOLD); hold(1, 1, HOLD);
      s_out = 1'b0; s_in = 1'b0;
      reset = 1'b1;
      #1;
      n_tests++;
      if ({ev_valid, ev_dir, full, gate_en, fault} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: got %b, required 00000",
                  {ev_valid, ev_dir, full, gate_en, fault});
      end
      repeat (2) @(posedge clk); #1;
      reset = 1'b0;
      check_drained("reset_mid");
      n_tests++;
      if (gate_en !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_idle: gate_en=%b, required 1", gate_en);
      end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 3; i++) begin
         sb.push_back('{v: 1'b1, d: 1'b1, f: 1'b0});
         sb.push_back('{v: 1'b1, d: 1'b0, f: 1'b0});
         hold(1, 0, HOLD); hold(1, 1, HOLD); hold(0, 1, HOLD); hold(0, 0, 2);
         hold(0, 1, HOLD); hold(1, 1, HOLD); hold(1, 0, HOLD); hold(0, 0, 2);
      end
      check_drained("back_to_back");
   endtask

`ifdef GATE_DEBOUNCE_EN
   task automatic test_glitch;
      sb.push_back('{v: 1'b1, d: 1'b0, f: 1'b0});
      hold(0, 1, HOLD); hold(1, 1, HOLD); hold(1, 0, HOLD);
      hold(0, 0, 3); hold(1, 0, HOLD + 5);
      n_tests++;
      if (sb.size() !== 1) begin
         n_fail++;
         $display("FAIL glitch_ignored: %0d pending, required 1", sb.size());
      end
      hold(0, 0, HOLD);
      check_drained("glitch");
   endtask
`endif

   initial begin
      test_reset();
      test_entry();
      test_exit();
      test_backout();
      test_ambig();
      test_full();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
`ifdef GATE_DEBOUNCE_EN
      test_glitch();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
